// File: rtl/pll_seq_if.sv
// PLL sequencer handshake bundle: lock input plus reset/status outputs.
// LOCK_LOSS_COUNT_EN adds the lock_loss_cnt status field.
interface pll_seq_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output retry_cnt,
    output lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retry_cnt,
    input  lock_loss_cnt
  );
`else
  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retry_cnt
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer on refclk: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional lock-loss event counter enabled by LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input logic        refclk,
  input logic        rst,
  pll_seq_if.master  seq
);

  localparam int MAX_AB =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t state, next_state;

  logic [CW-1:0] cnt;
  logic [3:0]    retry_q;
  logic [3:0]    retry_inc;
  logic          lock_m, lock_s;
  logic          cnt_en;
  logic          rst_done, lock_tmo, stable_done;
  logic          timeout;
  logic          pll_rst_d, sys_rst_d, ready_d, fault_d;
  logic          pll_rst_q, sys_rst_q, ready_q, fault_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= seq.pll_locked;
      lock_s <= lock_m;
    end
  end

  assign rst_done    = (cnt == CW'(RST_CYCLES - 1));
  assign lock_tmo    = (cnt == CW'(LOCK_TIMEOUT - 1));
  assign stable_done = (cnt == CW'(STABLE_CYCLES - 1));
  assign timeout     = (state == S_WAIT_LOCK) && !lock_s && lock_tmo;
  assign retry_inc   = retry_q + 4'd1;

  // counter only runs in timed states, so it never wraps
  assign cnt_en = (state == S_PLL_RST) ||
                  (state == S_WAIT_LOCK) ||
                  (state == S_STABLE);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= next_state;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      if (next_state != state)
        cnt <= '0;
      else if (cnt_en)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_PLL_RST:
        if (rst_done) next_state = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (lock_s)
          next_state = S_STABLE;
        else if (lock_tmo)
          next_state = (retry_inc == 4'(MAX_RETRIES)) ?
                       S_FAULT : S_PLL_RST;
      S_STABLE:
        if (!lock_s)
          next_state = S_WAIT_LOCK;
        else if (stable_done)
          next_state = S_RUN;
      S_RUN:
        if (!lock_s) next_state = S_PLL_RST;
      S_FAULT:
        next_state = S_FAULT;
      default:
        next_state = S_PLL_RST;
    endcase
  end

  // decode from next_state so outputs land on the transition edge
  always_comb begin
    pll_rst_d = 1'b1;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (next_state)
      S_PLL_RST:   pll_rst_d = 1'b1;
      S_WAIT_LOCK: pll_rst_d = 1'b0;
      S_STABLE:    pll_rst_d = 1'b0;
      S_RUN: begin
        pll_rst_d = 1'b0;
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      S_FAULT:     fault_d   = 1'b1;
      default:     pll_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      retry_q <= 4'd0;
    else if (next_state == S_RUN && state != S_RUN)
      retry_q <= 4'd0;
    else if (timeout)
      retry_q <= retry_inc;
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      loss_q <= 8'd0;
    else if (state == S_RUN && !lock_s && loss_q != 8'hff)
      loss_q <= loss_q + 8'd1;
  end

  assign seq.lock_loss_cnt = loss_q;
`endif

  assign seq.pll_rst   = pll_rst_q;
  assign seq.sys_rst   = sys_rst_q;
  assign seq.ready     = ready_q;
  assign seq.fault     = fault_q;
  assign seq.retry_cnt = retry_q;

endmodule
